seq_shift_add_multiplier: RTL and testbench



---
 rtl/arith_pkg.sv | 21 ++
 rtl/seq_shift_add_multiplier_if.sv | 29 ++
 rtl/mul_acc_reg.sv | 62 ++++++
 rtl/seq_shift_add_multiplier.sv | 90 +++++++++
 tb/tb_seq_shift_add_multiplier.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions for the multiplier and divider controllers.
// No logic of its own; types, widths and a counter-width helper.
// No flow control; compile-time constants only.
package arith_pkg;

    // Default operand width for the sequential multiplier.
    localparam int MUL_W = 10;

    // Controller states, shared with the divider controller.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Bits needed for an iteration counter that must be able to hold n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Start/operand/result bundle between the arithmetic controller and the multiplier.
// Purely wiring; no latency.
// Start is sampled only while the multiplier is idle; busy tells the master when.
interface seq_shift_add_multiplier_if
    import arith_pkg::*;
#(
    parameter int N = MUL_W
) ();

    logic           start;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    // The controller issues requests and reads back results.
    modport master (
        output start, a_in, b_in,
        input  busy, done, product
    );

    // The multiplier receives requests and drives status and product.
    modport slave (
        input  start, a_in, b_in,
        output busy, done, product
    );

endinterface

// File: rtl/mul_acc_reg.sv
// Accumulator/multiplier register pair of the shift-and-add datapath.
// One add-and-shift iteration per step cycle; load and clear take effect on the next edge.
// No backpressure; the owning FSM decides every cycle which control is active.
module mul_acc_reg
    import arith_pkg::*;
#(
    parameter int N = MUL_W
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [N-1:0] m_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] acc_o,
    output logic [N-1:0] q_o
);

    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] q_q,   q_d;
    logic [N:0]   sum;
    logic         carry;

    // Conditional add is kept N+1 bits wide so the carry survives into the shift.
    always_comb begin
        sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_i} : {(N + 1){1'b0}});
        carry = sum[N];
    end

    // Clear wins over load, load wins over an iteration; otherwise hold.
    always_comb begin
        acc_d = acc_q;
        q_d   = q_q;
        if (clr_i) begin
            acc_d = '0;
            q_d   = '0;
        end else if (load_i) begin
            acc_d = '0;
            q_d   = b_i;
        end else if (step_i) begin
            // {ACC,Q} <= {carry, sum[N-1:0], Q[N-1:1]}
            acc_d = {carry, sum[N-1:1]};
            q_d   = {sum[0], q_q[N-1:1]};
        end
    end

    // Register pair with asynchronous clear to zero.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            q_q   <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
        end
    end

    assign acc_o = acc_q;
    assign q_o   = q_q;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-and-add multiplier, N-bit operands, 2N-bit product.
// Start edge plus N iteration edges; done is a one-cycle pulse in the cycle after the last one.
// Start is only honoured in IDLE; requests while busy (including DONE) are dropped.
module seq_shift_add_multiplier
    import arith_pkg::*;
#(
    parameter int N = MUL_W
) (
    input  logic                        clock,
    input  logic                        rst,
    seq_shift_add_multiplier_if.slave   bus
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N-1:0]     m_q,     m_d;
    logic             load;
    logic             step;
    logic [N-1:0]     acc;
    logic [N-1:0]     q;

    // Next state, counter, multiplicand capture and datapath controls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    m_d     = bus.a_in;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and multiplicand registers; reset discards any operation in flight.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
        end
    end

    // The clear control exists for an abort-capable controller; this FSM never aborts.
    mul_acc_reg #(
        .N (N)
    ) u_acc (
        .clock  (clock),
        .rst    (rst),
        .clr_i  (1'b0),
        .load_i (load),
        .step_i (step),
        .m_i    (m_q),
        .b_i    (bus.b_in),
        .acc_o  (acc),
        .q_o    (q)
    );

    // Status decodes straight from the state register, so start never reaches busy/done combinationally.
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = {acc, q};

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;
    import arith_pkg::*;

    localparam int N = MUL_W;

    logic clock = 1'b0;
    logic rst   = 1'b0;

    seq_shift_add_multiplier_if #(.N(N)) bus_if ();

    seq_shift_add_multiplier #(.N(N)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; reports edges from start edge and busy cycles.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [2*N-1:0] p, output int lat, output int bcnt,
                          output bit seen);
        @(negedge clock);
        bus_if.start = 1'b1;
        bus_if.a_in  = a;
        bus_if.b_in  = b;
        @(posedge clock);
        @(negedge clock);
        bus_if.start = 1'b0;
        lat  = 1;
        bcnt = int'(bus_if.busy);
        seen = bus_if.done;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            bcnt += int'(bus_if.busy);
            if (bus_if.done) seen = 1'b1;
        end
        p = bus_if.product;
    endtask

    logic [2*N-1:0] p;
    logic [2*N-1:0] hold_p;
    int lat, bcnt, nd, last, idx;
    bit seen;
    logic [N-1:0] ra, rb;
    logic [N-1:0] pa [3];
    logic [N-1:0] pb [3];
    logic [2*N-1:0] pe [3];

    initial begin
        vecs[0] = '{a: 10'd13,   b: 10'd11,   exp: 20'd143};
        vecs[1] = '{a: 10'd1023, b: 10'd1023, exp: 20'd1046529};
        vecs[2] = '{a: 10'd0,    b: 10'd777,  exp: 20'd0};
        vecs[3] = '{a: 10'd1023, b: 10'd1,    exp: 20'd1023};
        vecs[4] = '{a: 10'd3,    b: 10'd4,    exp: 20'd12};

        bus_if.start = 1'b0;
        bus_if.a_in  = '0;
        bus_if.b_in  = '0;

        // Reset held for two cycles.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_busy",    32'(bus_if.busy),    32'd0);
        chk("reset_done",    32'(bus_if.done),    32'd0);
        chk("reset_product", 32'(bus_if.product), 32'd0);
        rst = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            run_op(vecs[v].a, vecs[v].b, p, lat, bcnt, seen);
            chk($sformatf("vec%0d_done_seen", v), 32'(seen), 32'd1);
            chk($sformatf("vec%0d_product", v), 32'(p), 32'(vecs[v].exp));
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(N + 1));
            chk($sformatf("vec%0d_busy_cycles", v), 32'(bcnt), 32'(N + 1));
            @(negedge clock);
            chk($sformatf("vec%0d_done_pulse", v), 32'(bus_if.done), 32'd0);
            chk($sformatf("vec%0d_busy_after", v), 32'(bus_if.busy), 32'd0);
            repeat (3) @(negedge clock);
            chk($sformatf("vec%0d_hold", v), 32'(bus_if.product), 32'(vecs[v].exp));
        end

        // Start pulses during CALC and in the DONE cycle are ignored.
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.a_in = 10'd5; bus_if.b_in = 10'd6;
        @(posedge clock);
        @(negedge clock);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clock);
        bus_if.start = 1'b1; bus_if.a_in = 10'd9; bus_if.b_in = 10'd9;
        @(negedge clock);
        bus_if.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus_if.done) seen = 1'b1;
            else @(negedge clock);
        end
        chk("ign_done_seen", 32'(seen), 32'd1);
        chk("ign_product",   32'(bus_if.product), 32'd30);
        bus_if.start = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b0;
        chk("ign_busy_fall", 32'(bus_if.busy), 32'd0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            nd += int'(bus_if.done);
        end
        chk("ign_no_second_done", 32'(nd), 32'd0);
        chk("ign_product_hold",   32'(bus_if.product), 32'd30);

        // Asynchronous reset in the middle of iteration 4.
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.a_in = 10'd100; bus_if.b_in = 10'd200;
        @(posedge clock);
        @(negedge clock);
        bus_if.start = 1'b0;
        repeat (4) @(posedge clock);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy",    32'(bus_if.busy),    32'd0);
        chk("arst_done",    32'(bus_if.done),    32'd0);
        chk("arst_product", 32'(bus_if.product), 32'd0);
        @(negedge clock);
        rst = 1'b1;
        run_op(10'd3, 10'd4, p, lat, bcnt, seen);
        chk("arst_restart_seen",    32'(seen), 32'd1);
        chk("arst_restart_product", 32'(p),    32'd12);

        // Start held high: one operation every N+2 cycles.
        pa[0] = 10'd7;   pb[0] = 10'd8;
        pa[1] = 10'd15;  pb[1] = 10'd15;
        pa[2] = 10'd512; pb[2] = 10'd2;
        for (int k = 0; k < 3; k++) pe[k] = 20'(int'(pa[k]) * int'(pb[k]));
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.a_in = pa[0]; bus_if.b_in = pb[0];
        @(posedge clock);
        nd = 0;
        last = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus_if.done) begin
                if (nd < 3) chk($sformatf("b2b_product%0d", nd), 32'(bus_if.product), 32'(pe[nd]));
                if (nd > 0) chk($sformatf("b2b_spacing%0d", nd), 32'(c - last), 32'(N + 2));
                last = c;
                nd++;
            end
            if (c % (N + 2) == 0) begin
                idx = c / (N + 2) + 1;
                if (idx < 3) begin
                    bus_if.a_in = pa[idx];
                    bus_if.b_in = pb[idx];
                end else begin
                    bus_if.start = 1'b0;
                end
            end
            @(posedge clock);
        end
        bus_if.start = 1'b0;
        chk("b2b_done_count", 32'(nd), 32'd3);

        // Operands wiggle every cycle after acceptance.
        @(negedge clock);
        bus_if.start = 1'b1; bus_if.a_in = 10'd20; bus_if.b_in = 10'd30;
        @(posedge clock);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            bus_if.a_in  = 10'($urandom);
            bus_if.b_in  = 10'($urandom);
            if (bus_if.done) seen = 1'b1;
            else @(posedge clock);
        end
        chk("wiggle_done_seen", 32'(seen), 32'd1);
        chk("wiggle_product",   32'(bus_if.product), 32'd600);

        // Random operands against plain integer multiplication.
        for (int r = 0; r < 20; r++) begin
            ra = 10'($urandom_range(0, 1023));
            rb = 10'($urandom_range(0, 1023));
            run_op(ra, rb, p, lat, bcnt, seen);
            chk($sformatf("rand%0d_seen", r),    32'(seen), 32'd1);
            chk($sformatf("rand%0d_product", r), 32'(p), 32'(int'(ra) * int'(rb)));
            chk($sformatf("rand%0d_latency", r), 32'(lat), 32'(N + 1));
            hold_p = p;
            repeat (2) @(negedge clock);
            chk($sformatf("rand%0d_hold", r), 32'(bus_if.product), 32'(hold_p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
